// File: rtl/stripes_pkg.sv
// Shared defaults and lane-select encoding for the two-lane striper/unstriper pair.
package stripes_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic {
    S_L0 = LANE0,
    S_L1 = LANE1
  } sel_state_e;
endpackage

// File: rtl/unstriper_2lane_lane_fifo.sv
// Per-lane elastic FIFO: registered storage, head word always presented on dout,
// empty/full derived from the occupancy count.
module lane_fifo
  import stripes_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              wr_en;
  logic              rd_en;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_2f) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/unstriper_2lane.sv
// Merges two striped lanes back into one word stream in strict lane0/lane1 order,
// stalling on whichever lane is due but empty.
module unstriper_2lane
  import stripes_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane0,
  input  logic              valid0,
  input  logic [DATA_W-1:0] lane1,
  input  logic              valid1,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              ovf0,
  output logic              ovf1,
  output logic              sel
);
  localparam int CW = $clog2(DEPTH) + 1;

  sel_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ovf0_q;
  logic              ovf1_q;

  logic [DATA_W-1:0] dout0;
  logic [DATA_W-1:0] dout1;
  logic [CW-1:0]     count0;
  logic [CW-1:0]     count1;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic              pop0;
  logic              pop1;
  logic              unused_cnt;

  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (state_q == S_L0) begin
      pop0 = !empty0;
    end else begin
      pop1 = !empty1;
    end
  end

  assign unused_cnt = ^{count0, count1};

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk_2f(clk_2f), .reset(reset), .push(valid0), .din(lane0), .pop(pop0),
    .dout(dout0), .count(count0), .full(full0), .empty(empty0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk_2f(clk_2f), .reset(reset), .push(valid1), .din(lane1), .pop(pop1),
    .dout(dout1), .count(count1), .full(full1), .empty(empty1)
  );

  // Lane-select FSM with registered output word and sticky overflow flags.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= S_L0;
      data_q  <= DATA_W'(0);
      valid_q <= 1'b0;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
    end else begin
      if (valid0 && full0 && !pop0) ovf0_q <= 1'b1;
      if (valid1 && full1 && !pop1) ovf1_q <= 1'b1;
      case (state_q)
        S_L0: begin
          if (!empty0) begin
            data_q  <= dout0;
            valid_q <= 1'b1;
            state_q <= S_L1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        S_L1: begin
          if (!empty1) begin
            data_q  <= dout1;
            valid_q <= 1'b1;
            state_q <= S_L0;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_L0;
        end
      endcase
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign ovf0     = ovf0_q;
  assign ovf1     = ovf1_q;
  assign sel      = state_q;
endmodule

// File: tb/tb_unstriper_2lane.sv
// Directed bench for unstriper_2lane: reset, alignment, skew stall, overflow,
// full push+pop, and mid-stream reset.
module tb_unstriper_2lane;
  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] lane0;
  logic        valid0;
  logic [31:0] lane1;
  logic        valid1;
  logic [31:0] dataOut;
  logic        validOut;
  logic        ovf0;
  logic        ovf1;
  logic        sel;

  int checks = 0;
  int errors = 0;

  always #5 clk_2f = ~clk_2f;

  unstriper_2lane dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane0(lane0), .valid0(valid0), .lane1(lane1), .valid1(valid1),
    .dataOut(dataOut), .validOut(validOut), .ovf0(ovf0), .ovf1(ovf1), .sel(sel)
  );

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic drive(input logic r, input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
    reset = r; valid0 = v0; lane0 = d0; valid1 = v1; lane1 = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'hAAAA0000 + 32'(i), 1'b1, 32'hBBBB0000 + 32'(i));
      checks++;
      if ({validOut, dataOut, ovf0, ovf1, sel} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state[%0d]: got v=%b d=%h o0=%b o1=%b sel=%b, expected all zero",
                 i, validOut, dataOut, ovf0, ovf1, sel);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (validOut !== 1'b0 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: got v=%b sel=%b, expected v=0 sel=0", validOut, sel);
    end
  endtask

  task automatic test_aligned;
    logic [31:0] ed [5];
    logic        ev [5];
    ed = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE);
      else if (i == 2) drive(1'b0, 1'b1, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFC);
      else             drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (validOut !== ev[i] || dataOut !== ed[i]) begin
        errors++;
        $display("FAIL aligned[%0d]: got v=%b d=%h, expected v=%b d=%h",
                 i, validOut, dataOut, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_skew;
    logic [31:0] ed [6];
    logic        ev [6];
    logic        es [6];
    ed = '{32'h0, 32'h11111111, 32'h11111111, 32'h11111111, 32'h22222222, 32'h33333333};
    ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0);
        2:       drive(1'b0, 1'b1, 32'h33333333, 1'b0, 32'h0);
        3:       drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h22222222);
        default: drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      endcase
      checks++;
      if (validOut !== ev[i] || dataOut !== ed[i] || sel !== es[i]) begin
        errors++;
        $display("FAIL skew[%0d]: got v=%b d=%h sel=%b, expected v=%b d=%h sel=%b",
                 i, validOut, dataOut, sel, ev[i], ed[i], es[i]);
      end
    end
    checks++;
    if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL skew_ovf: got o0=%b o1=%b, expected 0 0", ovf0, ovf1);
    end
  endtask

  task automatic test_overflow;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b0, 32'h0);
    checks++;
    if (ovf0 !== 1'b0 || dut.u_fifo0.count !== 3'd4 || sel !== 1'b1 || dataOut !== 32'hA0000001) begin
      errors++;
      $display("FAIL fill_no_drop: got o0=%b cnt=%0d sel=%b d=%h, expected o0=0 cnt=4 sel=1 d=a0000001",
               ovf0, dut.u_fifo0.count, sel, dataOut);
    end
    drive(1'b0, 1'b1, 32'hA0000006, 1'b0, 32'h0);
    checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b0 || dut.u_fifo0.count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: got o0=%b o1=%b cnt=%0d, expected o0=1 o1=0 cnt=4",
               ovf0, ovf1, dut.u_fifo0.count);
    end
  endtask

  task automatic test_full_push_pop;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hB0000001);
    checks++;
    if (validOut !== 1'b0 || sel !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: got v=%b sel=%b, expected v=0 sel=1", validOut, sel);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (validOut !== 1'b1 || dataOut !== 32'hB0000001 || sel !== 1'b0) begin
      errors++;
      $display("FAIL full_lane1: got v=%b d=%h sel=%b, expected v=1 d=b0000001 sel=0",
               validOut, dataOut, sel);
    end
    drive(1'b0, 1'b1, 32'hA0000006, 1'b0, 32'h0);
    checks++;
    if (ovf0 !== 1'b0 || dut.u_fifo0.count !== 3'd4 || validOut !== 1'b1 || dataOut !== 32'hA0000002) begin
      errors++;
      $display("FAIL full_push_pop: got o0=%b cnt=%0d v=%b d=%h, expected o0=0 cnt=4 v=1 d=a0000002",
               ovf0, dut.u_fifo0.count, validOut, dataOut);
    end
  endtask

  task automatic test_midstream_reset;
    logic [31:0] ed [8];
    logic        ev [8];
    logic        es [8];
    ed = '{32'h0, 32'hA0000001, 32'h0, 32'h0, 32'h0, 32'hD0000000, 32'hC0000001, 32'hC0000001};
    ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    es = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       drive(1'b0, 1'b1, 32'hA0000001, 1'b1, 32'hB0000001);
        1:       drive(1'b0, 1'b1, 32'hA0000002, 1'b1, 32'hB0000002);
        2:       drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        3:       drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0000001);
        4:       drive(1'b0, 1'b1, 32'hD0000000, 1'b0, 32'h0);
        default: drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      endcase
      checks++;
      if (validOut !== ev[i] || dataOut !== ed[i] || sel !== es[i]) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got v=%b d=%h sel=%b, expected v=%b d=%h sel=%b",
                 i, validOut, dataOut, sel, ev[i], ed[i], es[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; lane0 = 32'h0; lane1 = 32'h0;
    test_reset();
    test_aligned();
    test_skew();
    test_overflow();
    test_full_push_pop();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
